// File: rtl/cop0_pkg.sv
// cop0_pkg: shared COP0 register numbers, exception codes, Status/Cause
// field positions and the exception-controller FSM state encoding.
package cop0_pkg;

    // COP0 register numbers (rd field of mfc0/mtc0)
    localparam logic [4:0] REG_COUNT   = 5'd9;
    localparam logic [4:0] REG_COMPARE = 5'd11;
    localparam logic [4:0] REG_STATUS  = 5'd12;
    localparam logic [4:0] REG_CAUSE   = 5'd13;
    localparam logic [4:0] REG_EPC     = 5'd14;

    // ExcCode values
    localparam logic [4:0] EXC_INT = 5'd0;
    localparam logic [4:0] EXC_RI  = 5'd10;
    localparam logic [4:0] EXC_OV  = 5'd12;

    // Status field positions
    localparam int ST_IE    = 0;
    localparam int ST_EXL   = 1;
    localparam int ST_IM_LO = 8;
    localparam int ST_IM_HI = 15;

    // Cause field positions; IP bit 15 is the timer pending bit
    localparam int CA_EXC_LO = 2;
    localparam int CA_EXC_HI = 6;
    localparam int CA_IP_LO  = 10;
    localparam int CA_IP_HI  = 15;
    localparam int CA_TI     = 15;

    // Only IE, EXL and IM are software-writable in Status
    localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
    localparam logic [31:0] STATUS_RESET = 32'h0000_0002;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } cop0_state_e;

endpackage

// File: rtl/cop0_timer.sv
// cop0_timer: free-running Count, Compare and the sticky timer-pending bit.
// Only instantiated when COP0_TIMER_EN is defined.
module cop0_timer (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        count_we_i,
    input  logic        compare_we_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        ip_o
);

    logic [31:0] count_q;
    logic [31:0] compare_q;
    logic        ip_q;

    // Count wraps naturally; a Compare write clears pending and wins over a match
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q   <= '0;
            compare_q <= '0;
            ip_q      <= 1'b0;
        end else begin
            count_q <= count_we_i ? wdata_i : count_q + 32'd1;
            if (compare_we_i) begin
                compare_q <= wdata_i;
                ip_q      <= 1'b0;
            end else if (count_q == compare_q) begin
                ip_q <= 1'b1;
            end
        end
    end

    assign count_o   = count_q;
    assign compare_o = compare_q;
    assign ip_o      = ip_q;

endmodule

// File: rtl/cop0_exc_ctrl.sv
// cop0_exc_ctrl: COP0 Status/Cause/EPC, exception prioritisation and the
// RUN/FLUSH redirect FSM. Optional timer (Count/Compare) enabled by the
// macro COP0_TIMER_EN. IRQ_W must be at most 5 (Cause bits 14:10).
module cop0_exc_ctrl
    import cop0_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0180,
    parameter int          IRQ_W      = 5
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    input  logic             i_mfc0,
    input  logic             i_mtc0,
    input  logic             i_eret,
    input  logic             i_unknown_func,
    input  logic             i_overflow,
    input  logic [4:0]       i_cop0_reg,
    input  logic [31:0]      i_wdata,
    input  logic [31:0]      i_pc,
    input  logic [IRQ_W-1:0] i_irq,
    output logic [31:0]      o_rdata,
    output logic             o_redirect,
    output logic [31:0]      o_redirect_addr,
    output logic             o_stall,
    output logic [31:0]      o_epc
);

    cop0_state_e state_q, state_d;
    logic [31:0] status_q, status_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] target_q, target_d;
    logic [4:0]  exccode_q, exccode_d;
    logic [IRQ_W-1:0] ip_q;

    logic        timer_ip;
    logic [31:0] count_val;
    logic [31:0] compare_val;
    logic [5:0]  ip_field;
    logic [31:0] cause_rd;
    logic        run_valid;
    logic        irq_pend;
    logic        exc_take;
    logic        mtc0_ok;
    logic        eret_ok;
    logic [4:0]  exc_code;

    // mfc0 needs no decode: read data is driven from the register number alone
    logic unused_mfc0;
    assign unused_mfc0 = i_mfc0;

`ifdef COP0_TIMER_EN
    cop0_timer u_timer (
        .clk_i        (i_clk),
        .rst_i        (i_rst),
        .count_we_i   (mtc0_ok && (i_cop0_reg == REG_COUNT)),
        .compare_we_i (mtc0_ok && (i_cop0_reg == REG_COMPARE)),
        .wdata_i      (i_wdata),
        .count_o      (count_val),
        .compare_o    (compare_val),
        .ip_o         (timer_ip)
    );
`else
    assign timer_ip    = 1'b0;
    assign count_val   = '0;
    assign compare_val = '0;
`endif

    // Cause.IP view: external lines from bit 10 upward, timer on bit 15
    always_comb begin
        ip_field = '0;
        ip_field[IRQ_W-1:0] = ip_q;
        ip_field[CA_TI-CA_IP_LO] = timer_ip;
    end

    assign cause_rd  = {16'b0, ip_field, 3'b0, exccode_q, 2'b0};
    assign irq_pend  = status_q[ST_IE] & ~status_q[ST_EXL]
                     & (|(ip_field & status_q[CA_IP_HI:CA_IP_LO]));
    assign run_valid = (state_q == ST_RUN) && i_valid;
    assign exc_take  = run_valid && (i_unknown_func || i_overflow || irq_pend);
    assign exc_code  = i_unknown_func ? EXC_RI : (i_overflow ? EXC_OV : EXC_INT);
    assign mtc0_ok   = run_valid && i_mtc0 && !exc_take;
    assign eret_ok   = run_valid && i_eret && !exc_take;

    // Combinational mfc0 read mux; unimplemented numbers read zero
    always_comb begin
        o_rdata = '0;
        case (i_cop0_reg)
            REG_STATUS:  o_rdata = status_q;
            REG_CAUSE:   o_rdata = cause_rd;
            REG_EPC:     o_rdata = epc_q;
            REG_COUNT:   o_rdata = count_val;
            REG_COMPARE: o_rdata = compare_val;
            default:     o_rdata = '0;
        endcase
    end

    // Next-state: exceptions beat mtc0/eret; FLUSH always returns to RUN
    always_comb begin
        state_d   = state_q;
        status_d  = status_q;
        exccode_d = exccode_q;
        epc_d     = epc_q;
        target_d  = target_q;
        case (state_q)
            ST_RUN: begin
                if (exc_take) begin
                    exccode_d = exc_code;
                    if (!status_q[ST_EXL]) epc_d = i_pc;
                    status_d[ST_EXL] = 1'b1;
                    target_d = EXC_VECTOR;
                    state_d  = ST_FLUSH;
                end else begin
                    if (mtc0_ok) begin
                        case (i_cop0_reg)
                            REG_STATUS: status_d  = i_wdata & STATUS_WMASK;
                            REG_CAUSE:  exccode_d = i_wdata[CA_EXC_HI:CA_EXC_LO];
                            REG_EPC:    epc_d     = i_wdata;
                            default:    ;
                        endcase
                    end
                    if (eret_ok) begin
                        status_d[ST_EXL] = 1'b0;
                        target_d = epc_q;
                        state_d  = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    // State and architectural registers; reset drops any pending redirect at once
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= ST_RUN;
            status_q  <= STATUS_RESET;
            exccode_q <= '0;
            epc_q     <= '0;
            target_q  <= '0;
            ip_q      <= '0;
        end else begin
            state_q   <= state_d;
            status_q  <= status_d;
            exccode_q <= exccode_d;
            epc_q     <= epc_d;
            target_q  <= target_d;
            ip_q      <= i_irq;
        end
    end

    assign o_redirect      = (state_q == ST_FLUSH);
    assign o_stall         = (state_q == ST_FLUSH);
    assign o_redirect_addr = target_q;
    assign o_epc           = epc_q;

endmodule

// File: tb/tb_cop0_exc_ctrl.sv
// tb_cop0_exc_ctrl: directed scenarios followed by random traffic, all
// checked against a transaction-level model of the COP0 rules.
module tb_cop0_exc_ctrl;

    localparam logic [31:0] VEC = 32'h0000_0180;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid, i_mfc0, i_mtc0, i_eret, i_unknown_func, i_overflow;
    logic [4:0]  i_cop0_reg;
    logic [31:0] i_wdata, i_pc;
    logic [4:0]  i_irq;
    logic [31:0] o_rdata, o_redirect_addr, o_epc;
    logic        o_redirect, o_stall;

    int total = 0;
    int bad   = 0;

    // model state
    logic [31:0] m_status, m_epc, m_target;
    logic [4:0]  m_exc, m_ip;
    bit          m_flush;

    cop0_exc_ctrl #(.EXC_VECTOR(VEC), .IRQ_W(5)) dut (
        .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .i_mfc0(i_mfc0),
        .i_mtc0(i_mtc0), .i_eret(i_eret), .i_unknown_func(i_unknown_func),
        .i_overflow(i_overflow), .i_cop0_reg(i_cop0_reg), .i_wdata(i_wdata),
        .i_pc(i_pc), .i_irq(i_irq), .o_rdata(o_rdata), .o_redirect(o_redirect),
        .o_redirect_addr(o_redirect_addr), .o_stall(o_stall), .o_epc(o_epc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_status = 32'h0000_0002;
        m_epc = '0; m_target = '0; m_exc = '0; m_ip = '0; m_flush = 0;
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] r);
        case (r)
            5'd12:   return m_status;
            5'd13:   return {16'b0, 1'b0, m_ip, 3'b0, m_exc, 2'b0};
            5'd14:   return m_epc;
            default: return 32'h0;
        endcase
    endfunction

    task automatic idle();
        i_valid = 0; i_mfc0 = 0; i_mtc0 = 0; i_eret = 0;
        i_unknown_func = 0; i_overflow = 0;
    endtask

    // One clock: apply the COP0 rules to the current inputs, advance, compare
    task automatic cyc();
        logic [31:0] n_status, n_epc, n_target, obs;
        logic [4:0]  n_exc;
        bit          n_flush, pend, skip;
        n_status = m_status; n_epc = m_epc; n_target = m_target; n_exc = m_exc;
        n_flush = 0;
        pend = m_status[0] && !m_status[1]
               && ((({27'b0, m_ip} << 10) & m_status & 32'h0000_FC00) != 0);
        if (!m_flush && i_valid) begin
            if (i_unknown_func || i_overflow || pend) begin
                n_exc = i_unknown_func ? 5'd10 : (i_overflow ? 5'd12 : 5'd0);
                if (!m_status[1]) n_epc = i_pc;
                n_status[1] = 1'b1;
                n_target = VEC;
                n_flush = 1;
            end else begin
                if (i_mtc0) begin
                    if (i_cop0_reg == 5'd12) n_status = i_wdata & 32'h0000_FF03;
                    if (i_cop0_reg == 5'd13) n_exc = i_wdata[6:2];
                    if (i_cop0_reg == 5'd14) n_epc = i_wdata;
                end
                if (i_eret) begin
                    n_status[1] = 1'b0;
                    n_target = m_epc;
                    n_flush = 1;
                end
            end
        end
        @(posedge clk);
        #1;
        m_status = n_status; m_epc = n_epc; m_target = n_target;
        m_exc = n_exc; m_flush = n_flush; m_ip = i_irq;
        check("redirect", {31'b0, o_redirect}, {31'b0, m_flush});
        check("stall", {31'b0, o_stall}, {31'b0, m_flush});
        if (m_flush) check("redirect_addr", o_redirect_addr, m_target);
        check("epc", o_epc, m_epc);
        obs = o_rdata;
        skip = 0;
`ifdef COP0_TIMER_EN
        if (i_cop0_reg == 5'd13) obs = obs & 32'h0000_7FFF;
        if (i_cop0_reg == 5'd9 || i_cop0_reg == 5'd11) skip = 1;
`endif
        if (!skip) check("rdata", obs, m_read(i_cop0_reg));
    endtask

    initial begin
        idle();
        i_cop0_reg = 5'd0; i_wdata = '0; i_pc = '0; i_irq = '0;
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_redirect", {31'b0, o_redirect}, 32'h0);
        check("rst_stall", {31'b0, o_stall}, 32'h0);
        check("rst_epc", o_epc, 32'h0);
        i_cop0_reg = 5'd12; #1;
        check("rst_status", o_rdata, 32'h0000_0002);
        i_cop0_reg = 5'd13; #1;
        check("rst_cause", o_rdata, 32'h0);
`ifndef COP0_TIMER_EN
        i_cop0_reg = 5'd9; #1;
        check("count_absent", o_rdata, 32'h0);
`endif
        @(negedge clk);
        rst = 1'b0;

        // Status=0x401, then irq0 taken at pc 0x40
        i_valid = 1; i_mtc0 = 1; i_cop0_reg = 5'd12; i_wdata = 32'h0000_0401;
        cyc();
        check("status_written", o_rdata, 32'h0000_0401);
        idle(); i_irq = 5'b00001;
        cyc();
        i_valid = 1; i_pc = 32'h0000_0040; i_cop0_reg = 5'd13;
        cyc();
        check("irq_redirect", {31'b0, o_redirect}, 32'h1);
        check("irq_addr", o_redirect_addr, 32'h0000_0180);
        check("irq_epc", o_epc, 32'h0000_0040);
        check("irq_cause", o_rdata, 32'h0000_0400);
        idle(); i_irq = '0;
        cyc();
        check("pulse_one_cycle", {31'b0, o_redirect}, 32'h0);

        // RI and overflow together, with a suppressed mtc0 to EPC
        i_valid = 1; i_unknown_func = 1; i_overflow = 1; i_mtc0 = 1;
        i_cop0_reg = 5'd14; i_wdata = 32'h0000_DEAD; i_pc = 32'h0000_0048;
        cyc();
        check("ri_epc_kept", o_epc, 32'h0000_0040);
        idle(); i_cop0_reg = 5'd13; #1;
        check("ri_cause", o_rdata, 32'h0000_0028);
        cyc();

        // eret to 0x44
        i_valid = 1; i_mtc0 = 1; i_cop0_reg = 5'd14; i_wdata = 32'h0000_0044;
        cyc();
        idle(); i_valid = 1; i_eret = 1; i_cop0_reg = 5'd12;
        cyc();
        check("eret_addr", o_redirect_addr, 32'h0000_0044);
        check("eret_exl", o_rdata & 32'h2, 32'h0);
        idle();
        cyc();

        // nested overflow keeps EPC
        i_valid = 1; i_overflow = 1; i_pc = 32'h0000_0050;
        cyc();
        idle(); cyc();
        i_valid = 1; i_overflow = 1; i_pc = 32'h0000_0060; i_cop0_reg = 5'd13;
        cyc();
        check("nested_epc", o_epc, 32'h0000_0050);
        check("nested_cause", o_rdata, 32'h0000_0030);
        idle(); cyc();

        // reset asserted while in FLUSH
        i_valid = 1; i_overflow = 1; i_pc = 32'h0000_0070;
        cyc();
        idle();
        #2 rst = 1'b1;
        #1;
        check("rst_in_flush_redirect", {31'b0, o_redirect}, 32'h0);
        check("rst_in_flush_stall", {31'b0, o_stall}, 32'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        cyc();
        cyc();

        // random traffic
        for (int n = 0; n < 300; n++) begin
            int r;
            i_valid = ($urandom_range(3) != 0);
            i_mtc0 = ($urandom_range(3) == 0);
            i_eret = ($urandom_range(7) == 0);
            i_mfc0 = ($urandom_range(1) == 0);
            i_unknown_func = ($urandom_range(15) == 0);
            i_overflow = ($urandom_range(11) == 0);
            r = $urandom_range(4);
            case (r)
                0: i_cop0_reg = 5'd12;
                1: i_cop0_reg = 5'd13;
                2: i_cop0_reg = 5'd14;
                3: i_cop0_reg = 5'd0;
                default: i_cop0_reg = 5'd31;
            endcase
            i_wdata = $urandom() & 32'hFFFF_7FFF;
            i_pc = $urandom() & 32'hFFFF_FFFC;
            i_irq = ($urandom_range(3) == 0) ? 5'($urandom_range(31)) : 5'd0;
            cyc();
        end

`ifdef COP0_TIMER_EN
        begin
            int waited;
            idle(); i_irq = '0;
            rst = 1'b1; #1; model_reset();
            @(negedge clk); rst = 1'b0;
            i_valid = 1; i_mtc0 = 1; i_cop0_reg = 5'd9; i_wdata = 32'd0;
            cyc();
            i_cop0_reg = 5'd11; i_wdata = 32'd5;
            cyc();
            idle(); i_cop0_reg = 5'd13; #1;
            check("timer_clear_start", o_rdata & 32'h8000, 32'h0);
            waited = 0;
            for (int k = 0; k < 10 && o_rdata[15] !== 1'b1; k++) begin
                cyc();
                waited++;
            end
            check("timer_set_latency", 32'(waited), 32'd5);
            cyc();
            check("timer_sticky", o_rdata & 32'h8000, 32'h8000);
            i_valid = 1; i_mtc0 = 1; i_cop0_reg = 5'd11; i_wdata = 32'd1000;
            cyc();
            idle(); i_cop0_reg = 5'd13; #1;
            check("timer_rewrite_clears", o_rdata & 32'h8000, 32'h0);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
